// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, one full-subtractor cell, LSB first.
// Latency: operands accepted on edge E, result valid after edge E+WIDTH.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, stalling indefinitely.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake carrying a, b, bin
//   out_valid/out_ready result handshake carrying diff, bout, zero
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             brw;
    logic [CW-1:0]    cnt;

    // Full-subtractor cell on the current LSBs plus the running borrow.
    logic             d;
    logic             brw_nxt;
    logic [WIDTH-1:0] diff_nxt;

    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ brw;
        brw_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
        diff_nxt = {d, diff[WIDTH-1:1]};
    end

    // Handshake signals decode straight from registered state, so neither
    // depends combinationally on the opposite side's valid/ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    brw  <= brw_nxt;
                    diff <= diff_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Flags use the post-shift values so the last bit counts.
                        bout  <= brw_nxt;
                        zero  <= (diff_nxt == '0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
    logic clk;
    logic rst;

    // WIDTH=8 instance
    logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, zero8;
    logic [7:0] a8, b8, diff8;

    // WIDTH=3 instance
    logic       in_valid3, in_ready3, bin3, out_valid3, out_ready3, bout3, zero3;
    logic [2:0] a3, b3, diff3;

    int total;
    int bad;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8), .zero(zero8)
    );

    serial_sub #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .bin(bin3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .diff(diff3), .bout(bout3), .zero(zero3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 operation: accept, check exact latency, check result, drain.
    task automatic op8(input string name, input logic [7:0] av, input logic [7:0] bv,
                       input logic binv, input logic [7:0] ed, input logic eb, input logic ez);
        int n;
        n = 0;
        while (!in_ready8 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (!in_ready8) begin
            bad++;
            $display("FAIL %s_ready_timeout: in_ready=%0b required 1", name, in_ready8);
        end
        a8 = av; b8 = bv; bin8 = binv; in_valid8 = 1'b1; out_ready8 = 1'b0;
        tick();
        in_valid8 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (out_valid8 !== 1'b0 || in_ready8 !== 1'b0) begin
                bad++;
                $display("FAIL %s_run%0d: out_valid=%0b in_ready=%0b required 0 0", name, i, out_valid8, in_ready8);
            end
        end
        tick();
        total++;
        if (out_valid8 !== 1'b1) begin
            bad++;
            $display("FAIL %s_latency: out_valid=%0b required 1", name, out_valid8);
        end
        total++;
        if (diff8 !== ed || bout8 !== eb || zero8 !== ez) begin
            bad++;
            $display("FAIL %s_result: diff=%h bout=%0b zero=%0b required diff=%h bout=%0b zero=%0b",
                     name, diff8, bout8, zero8, ed, eb, ez);
        end
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        total++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL %s_drain: out_valid=%0b in_ready=%0b required 0 1", name, out_valid8, in_ready8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; out_ready8 = 1'b0;
        in_valid3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0; out_ready3 = 1'b0;
        tick();
        tick();
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || zero8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b diff=%h bout=%0b zero=%0b required 1 0 00 0 0",
                     in_ready8, out_valid8, diff8, bout8, zero8);
        end
        rst = 1'b0;
        tick();
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1 0", in_ready8, out_valid8);
        end
    endtask

    task automatic test_basic();
        op8("basic_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        op8("under_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        op8("under_00_ff_bin", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1);
        op8("zero_80_7f_bin", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);
    endtask

    // in_valid held high with out_ready high: one accept per WIDTH+2 cycles.
    task automatic test_back_to_back();
        int accepts;
        int results;
        accepts = 0;
        results = 0;
        a8 = 8'h80; b8 = 8'h7F; bin8 = 1'b1;
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (in_ready8) accepts++;
            total++;
            if (in_ready8 && out_valid8) begin
                bad++;
                $display("FAIL b2b_ready_valid_overlap%0d: in_ready=1 out_valid=1 required not both", i);
            end
            if (out_valid8) begin
                results++;
                total++;
                if (diff8 !== 8'h00 || bout8 !== 1'b0 || zero8 !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_result%0d: diff=%h bout=%0b zero=%0b required 00 0 1", i, diff8, bout8, zero8);
                end
            end
            tick();
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        total++;
        if (accepts != 3 || results != 3) begin
            bad++;
            $display("FAIL b2b_counts: accepts=%0d results=%0d required 3 3", accepts, results);
        end
        tick();
        total++;
        if (in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: in_ready=%0b required 1", in_ready8);
        end
    endtask

    task automatic test_backpressure();
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (out_valid8 !== 1'b1) begin
            bad++;
            $display("FAIL bp_done: out_valid=%0b required 1", out_valid8);
        end
        for (int i = 0; i < 5; i++) begin
            a8 = ~a8; b8 = b8 + 8'h11; bin8 = ~bin8;
            tick();
            total++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || diff8 !== 8'h1E || bout8 !== 1'b0 || zero8 !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall%0d: out_valid=%0b in_ready=%0b diff=%h bout=%0b zero=%0b required 1 0 1e 0 0",
                         i, out_valid8, in_ready8, diff8, bout8, zero8);
            end
        end
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1 0", in_ready8, out_valid8);
        end
        tick();
        in_valid8 = 1'b0;
        total++;
        if (in_ready8 !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: in_ready=%0b required 0", in_ready8);
        end
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (out_valid8 !== 1'b1 || diff8 !== 8'h22 || bout8 !== 1'b0 || zero8 !== 1'b0) begin
            bad++;
            $display("FAIL bp_next_result: out_valid=%0b diff=%h bout=%0b zero=%0b required 1 22 0 0",
                     out_valid8, diff8, bout8, zero8);
        end
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset_midop();
        a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        tick();
        in_valid8 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || zero8 !== 1'b0) begin
            bad++;
            $display("FAIL midop_async_reset: in_ready=%0b out_valid=%0b diff=%h bout=%0b zero=%0b required 1 0 00 0 0",
                     in_ready8, out_valid8, diff8, bout8, zero8);
        end
        tick();
        rst = 1'b0;
        tick();
        op8("after_reset_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_exhaustive3();
        logic [3:0] ref_full;
        logic [2:0] ed;
        logic       eb;
        logic       ez;
        int         lat;
        for (int i = 0; i < 128; i++) begin
            a3 = i[6:4]; b3 = i[3:1]; bin3 = i[0];
            ref_full = {1'b0, a3} - {1'b0, b3} - {3'b000, bin3};
            ed = ref_full[2:0];
            eb = ref_full[3];
            ez = (ed == 3'b000);
            total++;
            if (in_ready3 !== 1'b1) begin
                bad++;
                $display("FAIL ex3_ready%0d: in_ready=%0b required 1", i, in_ready3);
            end
            in_valid3 = 1'b1; out_ready3 = 1'b0;
            tick();
            in_valid3 = 1'b0;
            lat = 0;
            while (!out_valid3 && lat < 10) begin
                tick();
                lat++;
            end
            total++;
            if (lat != 3) begin
                bad++;
                $display("FAIL ex3_latency%0d: cycles=%0d required 3", i, lat);
            end
            total++;
            if (diff3 !== ed || bout3 !== eb || zero3 !== ez) begin
                bad++;
                $display("FAIL ex3_result a=%0d b=%0d bin=%0b: diff=%0d bout=%0b zero=%0b required %0d %0b %0b",
                         a3, b3, bin3, diff3, bout3, zero3, ed, eb, ez);
            end
            out_ready3 = 1'b1;
            tick();
            out_ready3 = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_exhaustive3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Bit-serial subtractor. It computes a - b - bin over WIDTH cycles, LSB first, using one full-subtractor cell and a borrow flip-flop. It trades latency for area against the parallel full-adder datapath. Operands arrive on a valid/ready input handshake, and the result leaves on a valid/ready output handshake.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  operands a, b, bin are valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow in.
out_valid  output  1  result valid (high only in DONE).
out_ready  input  1  consumer accepts the result.
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
bout  output  1  borrow out; 1 iff a < b + bin (unsigned).
zero  output  1  1 iff diff == 0.

Behaviour:
- Reset (async assert, any state): state=IDLE; in_ready=1, out_valid=0, diff=0, bout=0, zero=0. Shift registers, borrow flop and bit counter cleared. Reset mid-RUN or mid-DONE discards the operation; no partial result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load a_sr<=a, b_sr<=b, brw<=bin, cnt<=0; go to RUN.
  - a, b and bin are sampled only at this edge; later input changes are ignored.
- RUN: in_ready=0, out_valid=0. Each edge:
  - d = a_sr[0]^b_sr[0]^brw.
  - brw <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&brw).
  - a_sr, b_sr shift right by one.
  - diff shifts right with d entering the MSB.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1, the shift still happens and state goes to DONE. RUN lasts exactly WIDTH cycles.
- Entering DONE: bout <= final brw; zero <= (final diff == 0), computed including the last shifted bit.
- DONE:
  - out_valid=1; diff, bout and zero held stable.
  - On an edge with out_ready=1: go to IDLE.
  - out_ready low stalls indefinitely with outputs unchanged.
- Latency: accept edge E, out_valid high after edge E+WIDTH.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN cycles, DONE handshake, back in IDLE).
- Outputs between operations:
  - During RUN, diff shows partial shift contents and bout/zero keep their previous values. All are meaningful only while out_valid=1.
  - After leaving DONE, diff/bout/zero hold until the next accept.
- Simultaneous events:
  - in_valid=1 while in DONE (even with out_ready=1): not accepted, since in_ready=0. The operation is accepted in the following IDLE cycle if in_valid is still high.
  - in_valid must be held until in_ready; dropping it early is allowed and simply means no transfer.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid; both are decoded from registered state.
- Counter width: $clog2(WIDTH); must not wrap before WIDTH-1.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, bin=0 -> after 8 cycles out_valid=1, diff=0x1E, bout=0, zero=0.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, zero=0. Then a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1, zero=1.
3. a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0, zero=1. With in_valid held high continuously, check in_ready=0 throughout RUN/DONE and exactly one accept per operation.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands toggling -> diff/bout/zero unchanged, no new accept. Raise out_ready -> IDLE next cycle, new operands accepted the cycle after.
5. Reset mid-op: accept a=0xF0, b=0x0F, assert rst asynchronously after 3 RUN cycles -> outputs go to 0 and in_ready=1 immediately, without waiting for a clock. After release, a=0x10, b=0x01 -> diff=0x0F, bout=0.
6. Exhaustive at WIDTH=3: all 128 (a, b, bin) combinations against the reference model {bout,diff} = {1'b0,a} - b - bin, with zero=(diff==0). Check exact latency of 3 cycles for every case.
